// File: rtl/fft_out_pkg.sv
// rtl/fft_out_pkg.sv - shared types and helpers for the FFT output ping-pong store
package fft_out_pkg;

  typedef enum logic {FREE = 1'b0, FULL = 1'b1} bank_state_t;

  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_N_SAMPLES = 2048;
  localparam int DEF_LANES     = 32;

  function automatic int calc_out_w(input int sample_w, input int lanes);
    return sample_w * lanes;
  endfunction

  function automatic int calc_words(input int n_samples, input int lanes);
    return n_samples / lanes;
  endfunction

  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = idx;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        r = {r[30:0], t[0]};
        t = {1'b0, t[31:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_bank.sv
// rtl/fft_out_bank.sv - one WORDS x OUT_W bank, single-lane write port and registered word read
module fft_out_bank
  import fft_out_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int LANES    = DEF_LANES,
  parameter int WORDS    = DEF_N_SAMPLES / DEF_LANES,
  localparam int WIDX_W  = calc_idx_w(WORDS),
  localparam int LANE_W  = calc_idx_w(LANES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDX_W-1:0]            wr_word,
  input  logic [LANE_W-1:0]            wr_lane,
  input  logic [SAMPLE_W-1:0]          wr_data,
  input  logic                         rd_en,
  input  logic [WIDX_W-1:0]            rd_word,
  output logic [SAMPLE_W*LANES-1:0]    rd_data
);

  logic [LANES-1:0][SAMPLE_W-1:0] mem [WORDS];

  // Storage is deliberately unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_word][wr_lane] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_word];
  end

endmodule

// File: rtl/fft_output_pingpong.sv
// rtl/fft_output_pingpong.sv - double-buffered FFT result store, sample writes in, wide words out
module fft_output_pingpong
  import fft_out_pkg::*;
#(
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int N_SAMPLES   = DEF_N_SAMPLES,
  parameter int LANES       = DEF_LANES,
  parameter int BIT_REVERSE = 0,
  localparam int OUT_W      = calc_out_w(SAMPLE_W, LANES),
  localparam int WORDS      = calc_words(N_SAMPLES, LANES),
  localparam int IDX_W      = calc_idx_w(N_SAMPLES),
  localparam int WIDX_W     = calc_idx_w(WORDS),
  localparam int LANE_W     = calc_idx_w(LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                wr_last,
  output logic                wr_ready,
  output logic                rd_valid,
  input  logic                rd_en,
  input  logic [WIDX_W-1:0]   rd_index,
  output logic [OUT_W-1:0]    rd_data,
  output logic                rd_data_valid,
  input  logic                rd_release,
  input  logic                flush,
  output logic                overflow,
  output logic                underflow
);

  bank_state_t       state [2];
  logic              wb, rb, rd_sel;
  logic              write_ok, read_ok, commit, release_ok;
  logic [IDX_W-1:0]  waddr;
  logic [1:0]        bank_we, bank_re;
  logic [OUT_W-1:0]  bank_rd [2];

  always_comb begin
    wr_ready   = (state[wb] == FREE);
    rd_valid   = (state[rb] == FULL);
    write_ok   = wr_en && wr_ready && !flush;
    read_ok    = rd_en && rd_valid && !flush;
    commit     = write_ok && wr_last;
    release_ok = rd_release && rd_valid && !flush;
    waddr      = (BIT_REVERSE != 0) ? IDX_W'(bitrev(32'(wr_index), IDX_W)) : wr_index;
    bank_we     = '0;
    bank_we[wb] = write_ok;
    bank_re     = '0;
    bank_re[rb] = read_ok;
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_out_bank #(
      .SAMPLE_W (SAMPLE_W),
      .LANES    (LANES),
      .WORDS    (WORDS)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_we[g]),
      .wr_word (waddr[IDX_W-1 -: WIDX_W]),
      .wr_lane (waddr[LANE_W-1:0]),
      .wr_data (wr_data),
      .rd_en   (bank_re[g]),
      .rd_word (rd_index),
      .rd_data (bank_rd[g])
    );
  end

  // rd_sel remembers which bank served the last read so rd_data holds across underflow/flush.
  assign rd_data = bank_rd[rd_sel];

  // Commit and release always hit different banks: commit needs state[wb]==FREE, release state[rb]==FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state[0]      <= FREE;
      state[1]      <= FREE;
      wb            <= 1'b0;
      rb            <= 1'b0;
      rd_sel        <= 1'b0;
      rd_data_valid <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else if (flush) begin
      state[0]      <= FREE;
      state[1]      <= FREE;
      wb            <= 1'b0;
      rb            <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= read_ok;
      if (read_ok) rd_sel <= rb;
      if (wr_en && !wr_ready) overflow <= 1'b1;
      if ((rd_en || rd_release) && !rd_valid) underflow <= 1'b1;
      if (commit) begin
        state[wb] <= FULL;
        wb        <= ~wb;
      end
      if (release_ok) begin
        state[rb] <= FREE;
        rb        <= ~rb;
      end
    end
  end

endmodule

// File: tb/tb_fft_output_pingpong.sv
// tb/tb_fft_output_pingpong.sv - self-checking bench for fft_output_pingpong
module tb_fft_output_pingpong;
  localparam int SW = 16, N = 2048, L = 32, OW = 512, W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          wr_en = 0, wr_last = 0, rd_en = 0, rd_release = 0, flush = 0;
  logic [10:0]   wr_index = '0;
  logic [SW-1:0] wr_data = '0;
  logic [5:0]    rd_index = '0;

  logic          wr_ready, rd_valid, rd_data_valid, overflow, underflow;
  logic [OW-1:0] rd_data;
  logic          br_wr_ready, br_rd_valid, br_rd_data_valid, br_overflow, br_underflow;
  logic [OW-1:0] br_rd_data;

  fft_output_pingpong #(.SAMPLE_W(SW), .N_SAMPLES(N), .LANES(L), .BIT_REVERSE(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_en(rd_en),
    .rd_index(rd_index), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .rd_release(rd_release), .flush(flush), .overflow(overflow), .underflow(underflow));

  fft_output_pingpong #(.SAMPLE_W(SW), .N_SAMPLES(N), .LANES(L), .BIT_REVERSE(1)) dut_br (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(br_wr_ready), .rd_valid(br_rd_valid), .rd_en(rd_en),
    .rd_index(rd_index), .rd_data(br_rd_data), .rd_data_valid(br_rd_data_valid),
    .rd_release(rd_release), .flush(flush), .overflow(br_overflow), .underflow(br_underflow));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: sample-indexed banks plus FREE/FULL flags and two pointers.
  logic [SW-1:0] m_mem   [2][N];
  bit            m_known [2][N];
  bit            m_state [2];
  bit            m_wb, m_rb, m_ovf, m_unf, m_rdv, m_rdk;
  logic [OW-1:0] m_rdata;

  task automatic model_reset();
    m_state[0] = 0; m_state[1] = 0;
    m_wb = 0; m_rb = 0; m_ovf = 0; m_unf = 0; m_rdv = 0;
    m_rdata = '0; m_rdk = 1;
  endtask

  task automatic model_step();
    bit wrdy, rv;
    if (flush) begin
      m_state[0] = 0; m_state[1] = 0; m_wb = 0; m_rb = 0; m_rdv = 0;
    end else begin
      wrdy = !m_state[m_wb];
      rv   = m_state[m_rb];
      if (wr_en) begin
        if (wrdy) begin
          m_mem[m_wb][wr_index]   = wr_data;
          m_known[m_wb][wr_index] = 1;
          if (wr_last) begin m_state[m_wb] = 1; m_wb = !m_wb; end
        end else m_ovf = 1;
      end
      m_rdv = 0;
      if (rd_en) begin
        if (rv) begin
          m_rdv = 1; m_rdk = 1;
          for (int l = 0; l < L; l++) begin
            m_rdata[l*SW +: SW] = m_mem[m_rb][int'(rd_index)*L + l];
            m_rdk &= m_known[m_rb][int'(rd_index)*L + l];
          end
        end else m_unf = 1;
      end
      if (rd_release) begin
        if (rv) begin m_state[m_rb] = 0; m_rb = !m_rb; end
        else m_unf = 1;
      end
    end
  endtask

  task automatic compare_model();
    chk("wr_ready", wr_ready, m_state[m_wb] ? 1'b0 : 1'b1);
    chk("rd_valid", rd_valid, m_state[m_rb]);
    chk("rd_data_valid", rd_data_valid, m_rdv);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    if (m_rdk) chk("rd_data", rd_data, m_rdata);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    wr_en = 0; wr_last = 0; rd_en = 0; rd_release = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_model();
  endtask

  task automatic write_frame(input int add, input bit rnd);
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_index = 11'(i); wr_last = (i == N - 1);
      wr_data = rnd ? SW'($urandom) : SW'(i + add);
      tick();
    end
    idle();
  endtask

  function automatic int rev_idx(input int x, input int nb);
    int r = 0;
    for (int i = 0; i < nb; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  typedef struct {
    logic wr_en; logic [10:0] wr_index; logic [15:0] wr_data; logic wr_last;
    logic rd_en; logic [5:0] rd_index; logic rd_release; logic flush;
    logic e_wr_ready; logic e_rd_valid; logic e_rdv; logic e_ovf; logic e_unf;
  } vec_t;
  vec_t vt [7];

  initial begin
    int brw;
    vt[0] = '{1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 11'd0, 16'h0000, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 11'd3, 16'h0007, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b1, 11'd4, 16'h0009, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 11'd0, 16'h0000, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    #2;
    do_reset();
    chk("reset_rd_data", rd_data, '0);

    // Full frame i -> i, then read every word.
    write_frame(0, 0);
    tick();
    chk("commit_rd_valid", rd_valid, 1'b1);
    for (int w = 0; w < W; w++) begin
      rd_en = 1; rd_index = 6'(w);
      tick();
      chk("seq_rdv", rd_data_valid, 1'b1);
      if (w == 1)  chk("word1_lane0", rd_data[15:0], 16'd32);
      if (w == 63) chk("word63_lane31", rd_data[511:496], 16'd2047);
    end
    idle(); tick();
    rd_release = 1; tick(); idle();

    // Two committed frames, overflow, then drain in order.
    write_frame(0, 0);
    write_frame(16'h1000, 0);
    tick();
    chk("both_full_wr_ready", wr_ready, 1'b0);
    wr_en = 1; wr_index = 11'd5; wr_data = 16'hdead; tick(); idle();
    chk("overflow_set", overflow, 1'b1);
    rd_en = 1; rd_index = 0; tick(); idle();
    chk("frameA_w0", rd_data[15:0], 16'h0000);
    rd_release = 1; tick(); idle();
    rd_en = 1; rd_index = 0; tick(); idle();
    chk("frameB_w0", rd_data[15:0], 16'h1000);
    rd_release = 1; tick(); idle();

    // Asynchronous reset mid-fill.
    for (int i = 0; i <= 700; i++) begin
      wr_en = 1; wr_index = 11'(i); wr_data = 16'(i); tick();
    end
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Streaming: drain frame 1 during the tail of frame 2, commit and release together.
    do_reset();
    write_frame(0, 1);
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_index = 11'(i); wr_data = SW'($urandom); wr_last = (i == N - 1);
      rd_en = (i >= N - W); rd_index = 6'(i - (N - W)); rd_release = (i == N - 1);
      tick();
      if (i >= N - W) chk("stream_rd_valid", rd_valid, 1'b1);
    end
    for (int i = 0; i < 100; i++) begin
      wr_en = 1; wr_index = 11'(i); wr_data = SW'($urandom); wr_last = 0;
      rd_en = (i < W); rd_index = 6'(i); rd_release = 0;
      tick();
      if (i < W) chk("stream2_rd_valid", rd_valid, 1'b1);
    end
    idle();
    chk("stream_no_overflow", overflow, 1'b0);

    // Flush with both banks FULL.
    wr_en = 1; wr_index = 0; wr_data = 16'h55; wr_last = 1; tick(); idle();
    tick();
    chk("pre_flush_wr_ready", wr_ready, 1'b0);
    flush = 1; tick(); idle();
    chk("flush_wr_ready", wr_ready, 1'b1);
    chk("flush_rd_valid", rd_valid, 1'b0);

    // Table-driven vectors from reset.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      wr_en = vt[k].wr_en; wr_index = vt[k].wr_index; wr_data = vt[k].wr_data;
      wr_last = vt[k].wr_last; rd_en = vt[k].rd_en; rd_index = vt[k].rd_index;
      rd_release = vt[k].rd_release; flush = vt[k].flush;
      tick();
      chk($sformatf("vec%0d_wr_ready", k), wr_ready, vt[k].e_wr_ready);
      chk($sformatf("vec%0d_rd_valid", k), rd_valid, vt[k].e_rd_valid);
      chk($sformatf("vec%0d_rdv", k), rd_data_valid, vt[k].e_rdv);
      chk($sformatf("vec%0d_overflow", k), overflow, vt[k].e_ovf);
      chk($sformatf("vec%0d_underflow", k), underflow, vt[k].e_unf);
      if (k == 1) chk("underflow_rd_data_hold", rd_data, '0);
    end
    idle();

    // Bit-reversed instance: index 1 lands at sample 1024.
    do_reset();
    brw = rev_idx(1, 11) / L;
    wr_en = 1; wr_index = 11'd1; wr_data = 16'habcd; wr_last = 1; tick(); idle();
    rd_en = 1; rd_index = 6'(brw); tick(); idle();
    chk("bitrev_rdv", br_rd_data_valid, 1'b1);
    chk("bitrev_w32_l0", br_rd_data[15:0], 16'habcd);
    rd_release = 1; tick(); idle();

    // Randomized traffic against the reference.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wr_en      = ($urandom_range(0, 9) < 7);
      wr_index   = 11'($urandom_range(0, N - 1));
      wr_data    = SW'($urandom);
      wr_last    = ($urandom_range(0, 63) == 0);
      rd_en      = $urandom_range(0, 1) != 0;
      rd_index   = 6'($urandom_range(0, W - 1));
      rd_release = ($urandom_range(0, 19) == 0);
      flush      = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
